// File: rtl/bch_encoder_serial.sv
// rtl/bch_encoder_serial.sv - bit-serial systematic BCH encoder, message then parity MSB first.
// Optional macro BCH_ENC_PARITY_INV_EN inverts every emitted parity bit.
module bch_encoder_serial #(
   parameter int                     PARITY_W = 13,
   parameter logic [PARITY_W-1:0]    GEN_POLY = 13'h001B
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   input  logic in_data,
   input  logic in_last,
   output logic in_ready,
   output logic out_valid,
   output logic out_data,
   output logic out_last,
   input  logic out_ready,
   output logic busy
);

   localparam int CNT_W = $clog2(PARITY_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PARITY_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MSG  = 2'd1,
      PAR  = 2'd2
   } state_t;

   state_t              state;
   logic [PARITY_W-1:0] r;
   logic [CNT_W-1:0]    cnt;

   logic out_free;
   logic in_take;
   logic out_take;
   logic fb;
   logic par_bit;

   assign out_free = !out_valid || out_ready;
   // Gated by rst_n so the port reads 0 while reset is held, 1 the instant it releases.
   assign in_ready = rst_n && (state != PAR) && out_free;
   assign in_take  = in_valid && in_ready;
   assign out_take = out_valid && out_ready;
   assign fb       = in_data ^ r[PARITY_W-1];

`ifdef BCH_ENC_PARITY_INV_EN
   assign par_bit = ~r[PARITY_W-1];
`else
   assign par_bit = r[PARITY_W-1];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         r         <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (in_take) begin
            busy <= 1'b1;
         end else if (out_take && out_last) begin
            busy <= 1'b0;
         end

         case (state)
            IDLE, MSG: begin
               if (in_take) begin
                  r         <= {r[PARITY_W-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
                  out_valid <= 1'b1;
                  out_data  <= in_data;
                  out_last  <= 1'b0;
                  cnt       <= '0;
                  state     <= in_last ? PAR : MSG;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end
            end
            PAR: begin
               // Shifting out the remainder leaves r all zero after the final bit.
               if (out_free) begin
                  out_valid <= 1'b1;
                  out_data  <= par_bit;
                  r         <= {r[PARITY_W-2:0], 1'b0};
                  if (cnt == CNT_LAST) begin
                     out_last <= 1'b1;
                     cnt      <= '0;
                     state    <= IDLE;
                  end else begin
                     out_last <= 1'b0;
                     cnt      <= cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bch_encoder_serial.sv
// tb/tb_bch_encoder_serial.sv - scoreboard bench for bch_encoder_serial.
module tb_bch_encoder_serial;

   localparam int             PW  = 13;
   localparam logic [PW-1:0]  GEN = 13'h001B;
`ifdef BCH_ENC_PARITY_INV_EN
   localparam logic [PW-1:0]  INV_MASK = '1;
`else
   localparam logic [PW-1:0]  INV_MASK = '0;
`endif

   logic clk = 1'b0;
   logic rst_n, in_valid, in_data, in_last, in_ready;
   logic out_valid, out_data, out_last, out_ready, busy;

   always #5 clk = ~clk;

   bch_encoder_serial #(.PARITY_W(PW), .GEN_POLY(GEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .busy(busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0]    exp_q [$];
   logic [PW-1:0] par_q [$];
   logic          msg_buf [0:255];

   logic          toggle_mode = 1'b0;
   logic          mon_en = 1'b1;
   logic          par_pending = 1'b0;
   logic          gap_chk = 1'b0;
   logic          last_was_last = 1'b0;
   logic          prev_stall = 1'b0;
   logic          prev_d, prev_l;
   logic [1:0]    e_m;
   logic [PW-1:0] par_sh = '0;
   int            cyc = 0;
   int            last_cyc = 0;
   int            xfer_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Long division of m(x)*x^PW by g(x), independent of the LFSR form.
   function automatic logic [PW-1:0] ref_parity(input int len);
      logic [PW:0] rem;
      logic        b;
      rem = '0;
      for (int i = 0; i < len + PW; i++) begin
         b   = (i < len) ? msg_buf[i] : 1'b0;
         rem = {rem[PW-1:0], b};
         if (rem[PW]) rem = rem ^ {1'b1, GEN};
      end
      return rem[PW-1:0];
   endfunction

   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         out_ready = toggle_mode ? ~out_ready : 1'b1;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else if (mon_en) begin
            if (prev_stall) begin
               check("hold_valid", out_valid, 1'b1);
               check("hold_data", out_data, prev_d);
               check("hold_last", out_last, prev_l);
            end
            if (par_pending && !(out_valid && out_last))
               check("in_ready_par", in_ready, 1'b0);
            if (out_valid && out_ready) begin
               check("sb_nonempty", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  e_m = exp_q.pop_front();
                  check("out_data", out_data, e_m[1]);
                  check("out_last", out_last, e_m[0]);
               end
               if (gap_chk && last_was_last)
                  check("b2b_gap", (cyc - last_cyc) <= 2, 1'b1);
               par_sh        = {par_sh[PW-2:0], out_data};
               last_was_last = out_last;
               last_cyc      = cyc;
               xfer_cnt++;
               if (out_last) begin
                  par_q.push_back(par_sh);
                  par_pending = 1'b0;
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
         end
      end
   end

   task automatic send_bit(input logic b, input logic l, input int len);
      int n;
      logic [PW-1:0] p;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      in_last  = l;
      #1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("in_ready_wait", in_ready, 1'b1);
      @(posedge clk);
      exp_q.push_back({b, 1'b0});
      if (l) begin
         p = ref_parity(len) ^ INV_MASK;
         for (int k = PW - 1; k >= 0; k--) exp_q.push_back({p[k], k == 0});
         par_pending = 1'b1;
      end
   endtask

   task automatic send_msg(input int len, input logic idle_after);
      for (int i = 0; i < len; i++) send_bit(msg_buf[i], i == len - 1, len);
      if (idle_after) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         #3;
         n++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_par(input string tag, input logic [PW-1:0] val);
      check("par_seen", par_q.size() != 0, 1'b1);
      if (par_q.size() != 0) check(tag, par_q.pop_front(), val);
   endtask

   initial begin
      int len;
      int base;
      int n;
      rst_n = 1'b0; in_valid = 1'b0; in_data = 1'b0; in_last = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", in_ready, 1'b1);

      msg_buf[0] = 1'b1;
      send_msg(1, 1'b0);
      #1;
      check("busy_on", busy, 1'b1);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      wait_drain();
      check("busy_off", busy, 1'b0);
      expect_par("par_1", 13'h001B ^ INV_MASK);

      msg_buf[0] = 1'b1; msg_buf[1] = 1'b0;
      send_msg(2, 1'b1);
      wait_drain();
      expect_par("par_10", 13'h0036 ^ INV_MASK);

      for (int i = 0; i < 100; i++) msg_buf[i] = 1'b0;
      send_msg(100, 1'b1);
      wait_drain();
      expect_par("par_zero100", INV_MASK);

      toggle_mode = 1'b1;
      msg_buf[0] = 1'b1;
      send_msg(1, 1'b1);
      wait_drain();
      toggle_mode = 1'b0;
      expect_par("par_1_toggle", 13'h001B ^ INV_MASK);

      for (int t = 0; t < 4; t++) begin
         len = $urandom_range(1, 40);
         for (int i = 0; i < len; i++) msg_buf[i] = 1'($urandom_range(0, 1));
         toggle_mode = t[0];
         send_msg(len, 1'b1);
         wait_drain();
      end
      toggle_mode = 1'b0;
      par_q.delete();

      base = xfer_cnt;
      msg_buf[0] = 1'b1;
      send_msg(1, 1'b1);
      n = 0;
      while (xfer_cnt < base + 6 && n < 200) begin
         @(negedge clk);
         #3;
         n++;
      end
      check("reach_5th_par", xfer_cnt >= base + 6, 1'b1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_in_ready", in_ready, 1'b0);
      exp_q.delete();
      par_q.delete();
      par_pending = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      #2;
      check("post_rst_quiet", out_valid, 1'b0);
      send_msg(1, 1'b1);
      wait_drain();
      expect_par("par_after_rst", 13'h001B ^ INV_MASK);
      check("no_extra_cw", par_q.size(), 0);

      last_was_last = 1'b0;
      gap_chk = 1'b1;
      msg_buf[0] = 1'b1;
      send_msg(1, 1'b0);
      msg_buf[0] = 1'b1; msg_buf[1] = 1'b0;
      send_msg(2, 1'b1);
      wait_drain();
      gap_chk = 1'b0;
      expect_par("b2b_first", 13'h001B ^ INV_MASK);
      expect_par("b2b_second", 13'h0036 ^ INV_MASK);
      check("b2b_busy_off", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
